// File: rtl/tutorial_sched.sv
// tutorial_sched: round-robin scheduler sharing one `tutorial` evaluation unit
// between NREQ requesters.
//
// Ports:
//   clk                  clock, all state on rising edge
//   rst_n                synchronous active-low reset
//   req[NREQ]            per-lane request, held with stable operand until ack
//   op[5*NREQ]           operand lanes, lane i = op[5*i+4:5*i] = {a,b,c,d,r}
//   ack[NREQ]            one-hot one-cycle completion pulse
//   rsp_data[5]          captured unit result, held after ack
//   rsp_id[IDW]          served lane index, held after ack
//   busy                 high from grant through DONE
//   ua/ub/uc/ud/ur       registered drive to the unit inputs
//   uout[5]              unit result
module tutorial_sched #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IDW    = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [5*NREQ-1:0] op,
    output logic [NREQ-1:0]   ack,
    output logic [4:0]        rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy,
    output logic              ua,
    output logic              ub,
    output logic              uc,
    output logic              ud,
    output logic              ur,
    input  logic [4:0]        uout
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

    state_e          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  g_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] ack_q;
    logic [4:0]      rsp_data_q;
    logic [IDW-1:0]  rsp_id_q;
    logic            busy_q;
    logic [4:0]      u_q;

    // Grant selection: first set req bit searching from ptr upwards with wrap.
    logic [IDW-1:0] gnt_d;
    logic [4:0]     gnt_op_d;
    logic           found;
    logic [IDW:0]   sum;
    logic [IDW-1:0] lane;

    always_comb begin
        gnt_d    = '0;
        gnt_op_d = '0;
        found    = 1'b0;
        sum      = '0;
        lane     = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            lane = sum[IDW-1:0];
            if (!found && req[lane]) begin
                found = 1'b1;
                gnt_d = lane;
            end
        end
        // Constant-index mux keeps the operand select free of computed part-selects.
        for (int j = 0; j < int'(NREQ); j++) begin
            if (gnt_d == IDW'(j)) begin
                gnt_op_d = op[5*j +: 5];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            g_q        <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            busy_q     <= 1'b0;
            u_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        g_q     <= gnt_d;
                        u_q     <= gnt_op_d;
                        cnt_q   <= CW'(SETTLE - 1);
                        busy_q  <= 1'b1;
                        state_q <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        rsp_data_q <= uout;
                        rsp_id_q   <= g_q;
                        ack_q      <= NREQ'(1) << g_q;
                        state_q    <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= (g_q == IDW'(NREQ - 1)) ? '0 : g_q + 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack      = ack_q;
    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;
    assign busy     = busy_q;
    assign {ua, ub, uc, ud, ur} = u_q;

endmodule

// File: tb/tb_tutorial_sched.sv
// Directed bench for tutorial_sched: one instance with SETTLE=1 for the main
// sequence and one with SETTLE=3 for the reset-during-settle case.
module tb_tutorial_sched;

    logic        clk;
    logic        rst_n;

    logic [3:0]  req1, ack1, req3, ack3;
    logic [19:0] op1, op3;
    logic [4:0]  rsp1, rsp3, uout1, uout3;
    logic [1:0]  id1, id3;
    logic        busy1, busy3;
    logic        ua1, ub1, uc1, ud1, ur1;
    logic        ua3, ub3, uc3, ud3, ur3;

    int n_tests = 0;
    int n_fail  = 0;

    // Stand-in for the tutorial unit: fixed points 0->1 and 11001->4, else xor.
    function automatic logic [4:0] tut(input logic [4:0] v);
        case (v)
            5'b00000: tut = 5'h01;
            5'b11001: tut = 5'h04;
            default:  tut = v ^ 5'h15;
        endcase
    endfunction

    assign uout1 = tut({ua1, ub1, uc1, ud1, ur1});
    assign uout3 = tut({ua3, ub3, uc3, ud3, ur3});

    tutorial_sched #(.NREQ(4), .IDW(2), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .op(op1), .ack(ack1),
        .rsp_data(rsp1), .rsp_id(id1), .busy(busy1),
        .ua(ua1), .ub(ub1), .uc(uc1), .ud(ud1), .ur(ur1), .uout(uout1)
    );

    tutorial_sched #(.NREQ(4), .IDW(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .op(op3), .ack(ack3),
        .rsp_data(rsp3), .rsp_id(id3), .busy(busy3),
        .ua(ua3), .ub(ub3), .uc(uc3), .ud(ud3), .ur(ur3), .uout(uout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for any ack on dut1, bounded; n returns edges waited.
    task automatic wait_ack1(output int n);
        n = 0;
        while (ack1 == 4'b0 && n < 10) begin
            tick();
            n++;
        end
        chk("ack_timeout", {31'b0, ack1 != 4'b0}, 32'd1);
    endtask

    // Single-lane transaction on dut1 with SETTLE=1.
    task automatic txn1(input int lane, input logic [4:0] v, input string tag);
        op1[5*lane +: 5] = v;
        req1 = 4'b0001 << lane;
        tick();
        chk({tag, "_busy"}, {31'b0, busy1}, 32'd1);
        chk({tag, "_uop"}, {27'b0, ua1, ub1, uc1, ud1, ur1}, {27'b0, v});
        chk({tag, "_noack"}, {28'b0, ack1}, 32'd0);
        tick();
        chk({tag, "_ack"}, {28'b0, ack1}, {28'b0, 4'b0001 << lane});
        chk({tag, "_data"}, {27'b0, rsp1}, {27'b0, tut(v)});
        chk({tag, "_id"}, {30'b0, id1}, lane);
        req1 = 4'b0;
        tick();
        chk({tag, "_ackoff"}, {28'b0, ack1}, 32'd0);
        chk({tag, "_busyoff"}, {31'b0, busy1}, 32'd0);
        chk({tag, "_hold"}, {27'b0, rsp1}, {27'b0, tut(v)});
    endtask

    initial begin
        int n;
        int last;
        int now;
        rst_n = 1'b0;
        req1  = 4'hF;
        req3  = 4'h0;
        op1   = 20'hA5C3E;
        op3   = 20'h0;

        // Reset with all lanes requesting.
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_ack", {28'b0, ack1}, 32'd0);
            chk("rst_busy", {31'b0, busy1}, 32'd0);
            chk("rst_u", {27'b0, ua1, ub1, uc1, ud1, ur1}, 32'd0);
            chk("rst_data", {27'b0, rsp1}, 32'd0);
            chk("rst_id", {30'b0, id1}, 32'd0);
        end
        req1  = 4'h0;
        op1   = 20'h0;
        rst_n = 1'b1;
        tick();
        chk("idle_busy", {31'b0, busy1}, 32'd0);

        txn1(2, 5'b00000, "single_l2");
        txn1(0, 5'b11001, "second_l0");
        txn1(0, 5'b00000, "again_l0");

        // Wrap/fairness: ptr=1 now; lane 3 served, ptr wraps to 0.
        op1 = {5'b10110, 5'b00000, 5'b00000, 5'b01101};
        txn1(3, 5'b10110, "wrap_l3");
        req1 = 4'b1001;
        wait_ack1(n);
        chk("fair_first", {28'b0, ack1}, 32'h1);
        chk("fair_first_data", {27'b0, rsp1}, {27'b0, tut(5'b01101)});
        req1 = 4'b1000;
        tick();
        wait_ack1(n);
        chk("fair_second", {28'b0, ack1}, 32'h8);
        chk("fair_second_id", {30'b0, id1}, 32'd3);
        req1 = 4'b0;
        tick();
        tick();

        // Contention: all lanes, ptr=0, expect 0,1,2,3 three cycles apart.
        op1  = {5'b00011, 5'b11001, 5'b10000, 5'b00111};
        req1 = 4'hF;
        now  = 0;
        last = 0;
        for (int l = 0; l < 4; l++) begin
            wait_ack1(n);
            now += n;
            chk("cont_ack", {28'b0, ack1}, {28'b0, 4'b0001 << l});
            chk("cont_id", {30'b0, id1}, l);
            chk("cont_data", {27'b0, rsp1}, {27'b0, tut(op1[5*l +: 5])});
            if (l > 0) chk("cont_gap", now - last, 32'd3);
            last = now;
            req1[l] = 1'b0;
            tick();
            now++;
        end
        tick();

        // Reset during SETTLE on the SETTLE=3 instance.
        op3  = {5'b0, 5'b0, 5'b11001, 5'b0};
        req3 = 4'b0010;
        tick();
        chk("mid_busy", {31'b0, busy3}, 32'd1);
        chk("mid_u", {27'b0, ua3, ub3, uc3, ud3, ur3}, 32'h19);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_ack", {28'b0, ack3}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy3}, 32'd0);
        chk("mid_rst_u", {27'b0, ua3, ub3, uc3, ud3, ur3}, 32'd0);
        chk("mid_rst_data", {27'b0, rsp3}, 32'd0);
        tick();
        chk("mid_rst_noack", {28'b0, ack3}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("re_busy", {31'b0, busy3}, 32'd1);
        tick();
        chk("re_noack1", {28'b0, ack3}, 32'd0);
        tick();
        chk("re_noack2", {28'b0, ack3}, 32'd0);
        tick();
        chk("re_ack", {28'b0, ack3}, 32'h2);
        chk("re_data", {27'b0, rsp3}, 32'h04);
        chk("re_id", {30'b0, id3}, 32'd1);
        req3 = 4'b0;
        tick();
        chk("re_done", {27'b0, ack3, busy3}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tutorial_sched.md
# tutorial_sched

Round-robin scheduler that shares one `tutorial` evaluation unit between NREQ requesters. Each requester presents a 5-bit operand {a,b,c,d,r} with a req/ack handshake. The scheduler grants one requester, drives the unit's a/b/c/d/r inputs from registers, waits a fixed settle time, and captures the unit's 5-bit `out`. It then returns that result with the requester id. It sits between the requester logic and the single `tutorial` instance, which it owns exclusively.

## Interface
- NREQ, 4, number of requesters (2..2**IDW).
- IDW, 2, width of the requester id.
- SETTLE, 1, cycles the unit inputs are held before `out` is captured (≥1; 0 is illegal).

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- req  in  NREQ  request per lane; held high with stable operand until ack.
- op  in  5*NREQ  operand lanes; lane i = op[5*i+4:5*i] = {a,b,c,d,r}.
- ack  out  NREQ  one-hot, one-cycle completion pulse for the served lane.
- rsp_data  out  5  captured unit result; valid while ack is high, held afterwards.
- rsp_id  out  IDW  index of the served lane; valid with ack, held afterwards.
- busy  out  1  high from grant through the DONE state.
- ua, ub, uc, ud, ur  out  1 each  registered drive to the unit's a,b,c,d,r.
- uout  in  5  unit's `out`.

## Operation
- States: IDLE, SETTLE, DONE. Registers: ptr (round-robin start), g (granted lane), cnt.
- IDLE: if any req bit is high, grant lane g = the first set bit searching ptr, ptr+1, … with wrap at NREQ-1→0.
  - Load {ua,ub,uc,ud,ur} ← op lane g, set cnt ← SETTLE-1, busy ← 1, go to SETTLE.
  - If no req bit is high, stay in IDLE; ua..ur hold their last values.
- SETTLE: if cnt==0, then rsp_data ← uout, rsp_id ← g, ack[g] ← 1, go to DONE; else cnt ← cnt-1.
- DONE: ack ← 0, busy ← 0, ptr ← (g+1) mod NREQ, go to IDLE.
- req is sampled only in IDLE. Operand changes after grant are ignored.
- A req still high at the next IDLE sample is a new transaction. Requesters must drop req within one cycle of seeing ack.
- Round-robin fairness: a lane served is lowest priority next grant. With all lanes requesting, service order is 0,1,2,3,0,…
- A single continuously requesting lane is served back-to-back, one grant per SETTLE+2 cycles.

## Timing
- Reset values: ua=ub=uc=ud=ur=0, ack=0, rsp_data=0, rsp_id=0, busy=0, ptr=0, state=IDLE.
- Request sampled at edge k: ua..ur and busy update at k.
- ack is high for exactly one cycle, from edge k+SETTLE to edge k+SETTLE+1. rsp_data and rsp_id change at edge k+SETTLE.
- busy falls at edge k+SETTLE+1. The earliest next grant is at edge k+SETTLE+2.
- Throughput: one transaction per SETTLE+2 cycles.
- Simultaneous requests: exactly one grant per IDLE; losers keep req high and are served in later rounds.
- ptr wrap-around: ptr=NREQ-1 plus a grant → next ptr=0.
- Reset mid-operation (rst_n low at any edge) forces all reset values at that edge. A pending ack is never issued, and the transaction is dropped. The requester must re-issue it.
- At most one ack bit is high at any time.
- ack never appears without a preceding grant.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req=4'hF → ack=0, busy=0, ua..ur=0, rsp_data=5'h00 throughout.
- Single request: lane 2 op={0,0,0,0,0}, SETTLE=1 → ack=4'b0100 one cycle at edge k+1, rsp_data=5'h01, rsp_id=2, busy low at k+2.
- Second operand: lane 0 op={1,1,0,0,1} → rsp_data=5'h04, rsp_id=0. Then lane 0 again with op=0 → rsp_data=5'h01.
- Contention: req=4'hF held, each lane dropping req after its own ack → ack order lanes 0,1,2,3, each ack 3 cycles apart (SETTLE=1).
- Wrap / fairness: serve lane 3, then raise req=4'b1001 → lane 0 is granted before lane 3 is granted again.
- Reset mid-op: assert rst_n=0 while in SETTLE with SETTLE=3 → no ack pulse, all outputs at reset values. After release, a fresh req completes normally.
